// File: rtl/odu_chid_scheduler_if.sv
// ---------------------------------------------------------------------------
// odu_chid_scheduler_if
// Bundle of the scheduler's config, FIFO-flag and read-strobe signals.
//   start            : global run enable (level) from the config block
//   enable_chid      : per-channel enable from the config block
//   fifo_empty       : per-channel FIFO empty flag
//   fifo_read_enable : one-hot (or zero) read strobe to the channel FIFOs
//   chid_value       : channel ID of the current read
//   chid_valid       : a read strobe is issued this cycle
//   busy             : scheduler is in a burst
//   grant_count      : grants issued since reset (wraps at 0xFFFF)
// The slave modport is the scheduler's view; master is the surrounding
// config/FIFO side.
// ---------------------------------------------------------------------------
interface odu_chid_scheduler_if #(
  parameter int NUM_CH = 80,
  parameter int CHID_W = 7
);
  logic              start;
  logic [NUM_CH-1:0] enable_chid;
  logic [NUM_CH-1:0] fifo_empty;
  logic [NUM_CH-1:0] fifo_read_enable;
  logic [CHID_W-1:0] chid_value;
  logic              chid_valid;
  logic              busy;
  logic [15:0]       grant_count;

  modport slave (
    input  start, enable_chid, fifo_empty,
    output fifo_read_enable, chid_value, chid_valid, busy, grant_count
  );

  modport master (
    output start, enable_chid, fifo_empty,
    input  fifo_read_enable, chid_value, chid_valid, busy, grant_count
  );
endinterface

// File: rtl/odu_chid_scheduler.sv
// ---------------------------------------------------------------------------
// odu_chid_scheduler
// Round-robin read scheduler for the per-channel ODU generator FIFOs.
// Grants one channel at a time and reads it for up to BURST_LEN consecutive
// cycles, issuing at most one FIFO read strobe per cycle together with the
// channel-ID tag for the downstream data selector.
// Ports:
//   clk : system clock
//   rst : synchronous active-high reset
//   bus : odu_chid_scheduler_if.slave (config inputs, FIFO flags, strobes,
//         channel tag, busy and grant counter)
// ---------------------------------------------------------------------------
module odu_chid_scheduler #(
  parameter int NUM_CH    = 80,
  parameter int CHID_W    = 7,
  parameter int BURST_LEN = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  odu_chid_scheduler_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARB   = 2'd1,
    BURST = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CHID_W-1:0] ptr_q, ptr_d;
  logic [CHID_W-1:0] cur_q, cur_d;
  logic [7:0]        bcnt_q, bcnt_d;
  logic [15:0]       grant_count_q, grant_count_d;

  logic [NUM_CH-1:0] elig;
  logic              found;
  logic [CHID_W-1:0] grant_idx;
  int                arb_idx;
  logic              rd;
  logic              burst_end;
  logic [CHID_W-1:0] ptr_after_cur;

  // Eligibility is re-evaluated every cycle from the live flags.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_elig
    assign elig[gi] = bus.enable_chid[gi] & ~bus.fifo_empty[gi];
  end

  // First eligible channel at or after ptr, wrapping past NUM_CH-1.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    arb_idx   = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      arb_idx = int'(ptr_q) + k;
      if (arb_idx >= NUM_CH) arb_idx = arb_idx - NUM_CH;
      if (!found && elig[arb_idx]) begin
        found     = 1'b1;
        grant_idx = CHID_W'(arb_idx);
      end
    end
  end

  // The read strobe is combinational on the current flags so an empty or
  // disabled FIFO is never read, and it is suppressed in the reset cycle.
  assign rd = (state_q == BURST) && elig[cur_q] && (bcnt_q < 8'(BURST_LEN)) && !rst;

  // Burst ends on the last permitted read or on any cycle without a read.
  assign burst_end = !rd || (bcnt_q == 8'(BURST_LEN - 1));

  assign ptr_after_cur = (cur_q == CHID_W'(NUM_CH - 1)) ? '0 : cur_q + 1'b1;

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    cur_d         = cur_q;
    bcnt_d        = bcnt_q;
    grant_count_d = grant_count_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) state_d = ARB;
      end
      ARB: begin
        if (!bus.start) begin
          state_d = IDLE;
        end else if (found) begin
          state_d       = BURST;
          cur_d         = grant_idx;
          bcnt_d        = '0;
          grant_count_d = grant_count_q + 16'd1;
        end
      end
      BURST: begin
        if (rd) bcnt_d = bcnt_q + 8'd1;
        // Dropping start lets this cycle's read finish, then parks in IDLE.
        if (burst_end || !bus.start) begin
          ptr_d   = ptr_after_cur;
          state_d = bus.start ? ARB : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      cur_q         <= '0;
      bcnt_q        <= '0;
      grant_count_q <= '0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      cur_q         <= cur_d;
      bcnt_q        <= bcnt_d;
      grant_count_q <= grant_count_d;
    end
  end

  assign bus.fifo_read_enable = rd ? ({{(NUM_CH-1){1'b0}}, 1'b1} << cur_q) : '0;
  assign bus.chid_valid       = rd;
  // cur only changes on a grant, so outside BURST it holds the last channel.
  assign bus.chid_value       = cur_q;
  assign bus.busy             = (state_q == BURST) && !rst;
  assign bus.grant_count      = grant_count_q;

endmodule

// File: tb/tb_odu_chid_scheduler.sv
// ---------------------------------------------------------------------------
// tb_odu_chid_scheduler
// Directed bench for odu_chid_scheduler (NUM_CH=80, BURST_LEN=4). Inputs are
// driven 1 time unit after the rising edge and outputs are checked a further
// time unit later, mid-cycle.
// ---------------------------------------------------------------------------
module tb_odu_chid_scheduler;
  localparam int NUM_CH = 80;
  localparam int CHID_W = 7;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  odu_chid_scheduler_if #(.NUM_CH(NUM_CH), .CHID_W(CHID_W)) bus ();

  odu_chid_scheduler #(.NUM_CH(NUM_CH), .CHID_W(CHID_W), .BURST_LEN(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle: ch = expected read channel (-1 for none), gc = expected grant count.
  task automatic cyc(input string tag, input int ch, input int gc);
    logic [NUM_CH-1:0] e;
    e = '0;
    if (ch >= 0) e[ch] = 1'b1;
    #1;
    chk({tag, ":fre"}, 128'(bus.fifo_read_enable), 128'(e));
    chk({tag, ":valid"}, 128'(bus.chid_valid), 128'(ch >= 0));
    if (ch >= 0) chk({tag, ":chid"}, 128'(bus.chid_value), 128'(ch));
    chk({tag, ":gc"}, 128'(bus.grant_count), 128'(gc));
    $display("t=%0t %s rd_ch=%0d exp_ch=%0d gc=%0d", $time, tag,
             bus.chid_valid ? int'(bus.chid_value) : -1, ch, bus.grant_count);
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  int order [4] = '{3, 40, 79, 3};

  initial begin
    rst = 1'b1;
    bus.start = 1'b1;
    bus.enable_chid = '1;
    bus.fifo_empty = '0;
    tick();

    // Reset held 3 cycles with start and all channels eligible.
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("rst:busy", 128'(bus.busy), 128'(0));
      chk("rst:chid", 128'(bus.chid_value), 128'(0));
      cyc("rst", -1, 0);
    end
    rst = 1'b0;
    cyc("rel_idle", -1, 0);
    cyc("rel_arb", -1, 0);
    #1;
    chk("rel:busy", 128'(bus.busy), 128'(1));
    cyc("rel_first", 0, 1);

    // Single channel 5: bursts of 4 separated by one ARB cycle.
    bus.enable_chid = '0;
    bus.enable_chid[5] = 1'b1;
    do_reset();
    cyc("s5_idle", -1, 0);
    cyc("s5_arb", -1, 0);
    for (int i = 0; i < 4; i++) cyc("s5_b1", 5, 1);
    cyc("s5_arb2", -1, 1);
    for (int i = 0; i < 3; i++) cyc("s5_b2", 5, 2);
    // Reset mid-burst: no strobe in the reset cycle, then everything cleared.
    rst = 1'b1;
    cyc("s5_rst", -1, 2);
    rst = 1'b0;
    #1;
    chk("s5_rst:busy", 128'(bus.busy), 128'(0));
    cyc("s5_after", -1, 0);

    // Round robin over 3, 40, 79 with wrap back to 3.
    bus.enable_chid = '0;
    bus.enable_chid[3] = 1'b1;
    bus.enable_chid[40] = 1'b1;
    bus.enable_chid[79] = 1'b1;
    do_reset();
    cyc("rr_idle", -1, 0);
    cyc("rr_arb", -1, 0);
    for (int g = 0; g < 4; g++) begin
      for (int i = 0; i < 4; i++) cyc("rr_rd", order[g], g + 1);
      cyc("rr_arb", -1, g + 1);
    end

    // Channel 10 runs empty after two reads; next grant goes to 12.
    bus.enable_chid = '0;
    bus.enable_chid[10] = 1'b1;
    bus.enable_chid[12] = 1'b1;
    do_reset();
    cyc("em_idle", -1, 0);
    cyc("em_arb", -1, 0);
    cyc("em_rd", 10, 1);
    cyc("em_rd", 10, 1);
    bus.fifo_empty[10] = 1'b1;
    #1;
    chk("em_empty:busy", 128'(bus.busy), 128'(1));
    cyc("em_empty", -1, 1);
    cyc("em_arb2", -1, 1);
    cyc("em_next", 12, 2);
    bus.fifo_empty = '0;

    // Start dropped during the 2nd read of a burst on 20; resume at 21.
    bus.enable_chid = '0;
    bus.enable_chid[20] = 1'b1;
    bus.enable_chid[21] = 1'b1;
    do_reset();
    cyc("sd_idle", -1, 0);
    cyc("sd_arb", -1, 0);
    cyc("sd_rd1", 20, 1);
    bus.start = 1'b0;
    cyc("sd_rd2", 20, 1);
    #1;
    chk("sd_idle:busy", 128'(bus.busy), 128'(0));
    chk("sd_idle:chid", 128'(bus.chid_value), 128'(20));
    cyc("sd_idle", -1, 1);
    bus.start = 1'b1;
    cyc("sd_idle2", -1, 1);
    cyc("sd_arb2", -1, 1);
    cyc("sd_resume", 21, 2);

    // Nothing enabled: parked in ARB, then ch0 enabled is granted next cycle.
    bus.enable_chid = '0;
    do_reset();
    cyc("ne_idle", -1, 0);
    for (int i = 0; i < 5; i++) cyc("ne_arb", -1, 0);
    bus.enable_chid[0] = 1'b1;
    cyc("ne_en0", -1, 0);
    cyc("ne_rd0", 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
